// File: rtl/if_stage.sv
// Instruction-fetch stage: architectural PC, instruction-memory address and the
// IF/ID pipeline register, tolerant of a variable-latency memory via im_ready.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] pc_next,
  input  logic        im_ready,
  input  logic [31:0] im_rdata,
  output logic [31:0] im_addr,
  output logic [31:0] pc_if,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        valid_d
);

  typedef enum logic {S_FETCH, S_WAIT} state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] pend_pc_reg;
  logic [31:0] instr_reg;
  logic [31:0] pc_d_reg;
  logic [31:0] pc8_d_reg;
  logic        valid_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      pc_reg      <= RESET_PC;
      pend_pc_reg <= 32'h0;
      instr_reg   <= NOP_INSTR;
      pc_d_reg    <= 32'h0;
      pc8_d_reg   <= 32'h0;
      valid_reg   <= 1'b0;
    end else begin
      // PC / FSM advance ignores flush; flush only affects what IF/ID captures.
      if (!stall) begin
        if (im_ready) begin
          pc_reg    <= (state_reg == S_WAIT) ? pend_pc_reg : pc_next;
          state_reg <= S_FETCH;
        end else if (state_reg == S_FETCH) begin
          pend_pc_reg <= pc_next;
          state_reg   <= S_WAIT;
        end
      end

      // Bubble keeps pc_d/pc8_d so a later jal link value stays consistent.
      if (flush || (!stall && !im_ready)) begin
        instr_reg <= NOP_INSTR;
        valid_reg <= 1'b0;
      end else if (!stall) begin
        instr_reg <= im_rdata;
        pc_d_reg  <= pc_reg;
        pc8_d_reg <= pc_reg + 32'd8;
        valid_reg <= 1'b1;
      end
    end
  end

  assign pc_if   = pc_reg;
  assign im_addr = pc_reg;
  assign instr_d = instr_reg;
  assign pc_d    = pc_d_reg;
  assign pc8_d   = pc8_d_reg;
  assign valid_d = valid_reg;

endmodule
